dma_queue_arbiter: RTL and testbench

Shares the single DMA descriptor control/status (DCS) Avalon-MM slave between the send-queue and receive-queue DMA request FIFOs. The block picks one non-empty FIFO by round-robin (optionally weighted) and latches its 112-bit DMA request. It writes the request to the DCS as four 32-bit words under `DCSWaitRequest` back-pressure, then pops the granted FIFO. It sits between the RDMA operation FIFOs and the DMA engine's descriptor port.

---
 rtl/dma_queue_arbiter.sv | 147 ++++++++++++++
 tb/tb_dma_queue_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_queue_arbiter.sv
// Round-robin arbiter that moves SQ/RQ DMA requests into the DCS descriptor slave as four words.
// Define DMA_ARB_WEIGHT_EN for weighted round-robin using SQ_WEIGHT / RQ_WEIGHT.
module dma_queue_arbiter #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         SQ_WEIGHT = 2,
    parameter int         RQ_WEIGHT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         SqDmaFifoEmpty,
    input  logic [111:0] SqDmaFifoData,
    output logic         SqDmaFifoPop,
    input  logic         RqDmaFifoEmpty,
    input  logic [111:0] RqDmaFifoData,
    output logic         RqDmaFifoPop,
    output logic [7:0]   DCSAddress,
    output logic         DCSChipSelect,
    output logic         DCSWrite,
    output logic [31:0]  DCSWriteData,
    output logic [3:0]   DCSByteEnable,
    input  logic         DCSWaitRequest,
    output logic         busy,
    output logic         grantSq
);

    typedef enum logic [1:0] {IDLE, WRITE, POP} stateT;

    stateT        state;
    stateT        nextState;
    logic [1:0]   idx;
    logic [111:0] hold;
    logic         lastGrantSq;
    logic         pickSq;
    logic         grantNow;
    logic         wordAccepted;

    assign grantNow     = (state == IDLE) && enable && (!SqDmaFifoEmpty || !RqDmaFifoEmpty);
    assign wordAccepted = (state == WRITE) && !DCSWaitRequest;

`ifdef DMA_ARB_WEIGHT_EN
    localparam logic [3:0] SqWeight = 4'(SQ_WEIGHT);
    localparam logic [3:0] RqWeight = 4'(RQ_WEIGHT);

    logic [3:0] weightCnt;
    logic       stayOnTie;

    // A zero count means no streak is running yet, so a tie alternates as in plain round-robin.
    always_comb begin
        stayOnTie = (weightCnt != 4'd0) && (weightCnt < (lastGrantSq ? SqWeight : RqWeight));
        if (SqDmaFifoEmpty)      pickSq = 1'b0;
        else if (RqDmaFifoEmpty) pickSq = 1'b1;
        else                     pickSq = stayOnTie ? lastGrantSq : !lastGrantSq;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            weightCnt <= 4'd0;
        end else if (grantNow) begin
            if (SqDmaFifoEmpty || RqDmaFifoEmpty || (pickSq != lastGrantSq))
                weightCnt <= 4'd1;
            else
                weightCnt <= weightCnt + 4'd1;
        end
    end
`else
    always_comb begin
        if (SqDmaFifoEmpty)      pickSq = 1'b0;
        else if (RqDmaFifoEmpty) pickSq = 1'b1;
        else                     pickSq = !lastGrantSq;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx         <= 2'd0;
            lastGrantSq <= 1'b0;
            grantSq     <= 1'b0;
        end else begin
            if (grantNow) begin
                idx     <= 2'd0;
                grantSq <= pickSq;
            end else if (wordAccepted) begin
                idx <= idx + 2'd1;
            end
            if (state == POP) lastGrantSq <= grantSq;
        end
    end

    // NOTE: the holding register has no reset; its contents are only observed in WRITE, after a grant loads it.
    always_ff @(posedge clock) begin
        if (grantNow) hold <= pickSq ? SqDmaFifoData : RqDmaFifoData;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (grantNow) nextState = WRITE;
            WRITE:   if (wordAccepted && (idx == 2'd3)) nextState = POP;
            POP:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        DCSWrite      = 1'b0;
        DCSChipSelect = 1'b0;
        DCSAddress    = 8'h00;
        DCSWriteData  = 32'h0;
        DCSByteEnable = 4'h0;
        SqDmaFifoPop  = 1'b0;
        RqDmaFifoPop  = 1'b0;
        busy          = (state != IDLE);
        unique case (state)
            WRITE: begin
                DCSWrite      = 1'b1;
                DCSChipSelect = 1'b1;
                DCSAddress    = BASE_ADDR + {6'd0, idx};
                DCSByteEnable = (idx == 2'd3) ? 4'h3 : 4'hF;
                unique case (idx)
                    2'd0: DCSWriteData = hold[31:0];
                    2'd1: DCSWriteData = hold[63:32];
                    2'd2: DCSWriteData = hold[95:64];
                    2'd3: DCSWriteData = {16'h0, hold[111:96]};
                endcase
            end
            POP: begin
                SqDmaFifoPop = grantSq;
                RqDmaFifoPop = !grantSq;
            end
            default: ;
        endcase
    end

    // The granted FIFO cannot drain before its pop because this block is its only consumer.
    assert property (@(posedge clock) disable iff (reset) !(SqDmaFifoPop && SqDmaFifoEmpty));
    assert property (@(posedge clock) disable iff (reset) !(RqDmaFifoPop && RqDmaFifoEmpty));
    assert property (@(posedge clock) (SQ_WEIGHT inside {[1:15]}) && (RQ_WEIGHT inside {[1:15]}));

endmodule

// File: tb/tb_dma_queue_arbiter.sv
// Directed self-checking bench for dma_queue_arbiter with show-ahead FIFO models on both queues.
`timescale 1ns/1ps
module tb_dma_queue_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         SqDmaFifoEmpty;
    logic [111:0] SqDmaFifoData;
    logic         SqDmaFifoPop;
    logic         RqDmaFifoEmpty;
    logic [111:0] RqDmaFifoData;
    logic         RqDmaFifoPop;
    logic [7:0]   DCSAddress;
    logic         DCSChipSelect;
    logic         DCSWrite;
    logic [31:0]  DCSWriteData;
    logic [3:0]   DCSByteEnable;
    logic         DCSWaitRequest;
    logic         busy;
    logic         grantSq;

    int passCnt  = 0;
    int totalCnt = 0;

    localparam logic [111:0] HEAD = 112'h1234_5678_9ABC_DEF0_0123_4567_89AB;

    // {DCSWrite, DCSChipSelect, DCSAddress, DCSByteEnable, DCSWriteData}
    localparam logic [45:0] W0 = {1'b1, 1'b1, 8'h00, 4'hF, 32'h456789AB};
    localparam logic [45:0] W1 = {1'b1, 1'b1, 8'h01, 4'hF, 32'hDEF00123};
    localparam logic [45:0] W2 = {1'b1, 1'b1, 8'h02, 4'hF, 32'h56789ABC};
    localparam logic [45:0] W3 = {1'b1, 1'b1, 8'h03, 4'h3, 32'h00001234};
    localparam logic [45:0] DI = 46'h0;
    // {SqDmaFifoPop, RqDmaFifoPop, busy, grantSq}
    localparam logic [3:0] T_BUSY = 4'b0011;
    localparam logic [3:0] T_POP  = 4'b1011;
    localparam logic [3:0] T_IDLE = 4'b0001;
    localparam logic [3:0] T_ZERO = 4'b0000;

    logic [111:0] sqMem [8];
    logic [111:0] rqMem [8];
    logic [2:0]   sqRd = '0;
    logic [2:0]   sqWr = '0;
    logic [2:0]   rqRd = '0;
    logic [2:0]   rqWr = '0;

    assign SqDmaFifoEmpty = (sqRd == sqWr);
    assign SqDmaFifoData  = sqMem[sqRd];
    assign RqDmaFifoEmpty = (rqRd == rqWr);
    assign RqDmaFifoData  = rqMem[rqRd];

    always @(posedge clock) begin
        if (SqDmaFifoPop) sqRd <= sqRd + 3'd1;
        if (RqDmaFifoPop) rqRd <= rqRd + 3'd1;
    end

    always #5 clock = ~clock;

    dma_queue_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .SqDmaFifoEmpty (SqDmaFifoEmpty),
        .SqDmaFifoData  (SqDmaFifoData),
        .SqDmaFifoPop   (SqDmaFifoPop),
        .RqDmaFifoEmpty (RqDmaFifoEmpty),
        .RqDmaFifoData  (RqDmaFifoData),
        .RqDmaFifoPop   (RqDmaFifoPop),
        .DCSAddress     (DCSAddress),
        .DCSChipSelect  (DCSChipSelect),
        .DCSWrite       (DCSWrite),
        .DCSWriteData   (DCSWriteData),
        .DCSByteEnable  (DCSByteEnable),
        .DCSWaitRequest (DCSWaitRequest),
        .busy           (busy),
        .grantSq        (grantSq)
    );

    function automatic logic [49:0] dutView();
        return {DCSWrite, DCSChipSelect, DCSAddress, DCSByteEnable, DCSWriteData,
                SqDmaFifoPop, RqDmaFifoPop, busy, grantSq};
    endfunction

    task automatic push_sq(input logic [111:0] d);
        sqMem[sqWr] = d;
        sqWr = sqWr + 3'd1;
    endtask

    task automatic push_rq(input logic [111:0] d);
        rqMem[rqWr] = d;
        rqWr = rqWr + 3'd1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        totalCnt++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        else passCnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        DCSWaitRequest = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        totalCnt++;
        if (dutView() !== 50'h0) $display("FAIL reset_outputs: got %h required 0", dutView());
        else passCnt++;
        reset = 1'b0;
    endtask

    task automatic test_sq_only();
        logic [49:0] expTab [6];
        expTab = '{{W0, T_BUSY}, {W1, T_BUSY}, {W2, T_BUSY}, {W3, T_BUSY},
                   {DI, T_POP}, {DI, T_IDLE}};
        wait_idle();
        push_sq(HEAD);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            totalCnt++;
            if (dutView() !== expTab[c])
                $display("FAIL sq_only cycle T+%0d: got %h required %h", c + 1, dutView(), expTab[c]);
            else passCnt++;
        end
    endtask

    task automatic test_round_robin();
        logic        expOrder [6];
        logic        order [6];
        logic [31:0] w0Log [6];
        logic [31:0] expW0;
        int          nPop = 0;
        int          nW0 = 0;
        int          sqK = 0;
        int          rqK = 0;
        logic        bothSeen = 1'b0;
`ifdef DMA_ARB_WEIGHT_EN
        expOrder = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        expOrder = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        wait_idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_sq({16'hC0DE, 64'h0, 32'h5A00_0000 + 32'(i)});
            push_rq({16'hBEEF, 64'h0, 32'hA500_0000 + 32'(i)});
        end
        for (int cyc = 0; cyc < 100 && nPop < 6; cyc++) begin
            @(negedge clock);
            if (SqDmaFifoPop && RqDmaFifoPop) bothSeen = 1'b1;
            if (DCSWrite && DCSAddress == 8'h00 && nW0 < 6) begin
                w0Log[nW0] = DCSWriteData;
                nW0++;
            end
            if (SqDmaFifoPop || RqDmaFifoPop) begin
                order[nPop] = SqDmaFifoPop;
                nPop++;
            end
        end
        totalCnt++;
        if (nPop != 6) $display("FAIL rr_pop_count: got %0d pops, required 6", nPop);
        else passCnt++;
        totalCnt++;
        if (bothSeen !== 1'b0) $display("FAIL rr_pops_exclusive: both pops seen high together");
        else passCnt++;
        for (int k = 0; k < 6; k++) begin
            totalCnt++;
            if (order[k] !== expOrder[k])
                $display("FAIL rr_grant_%0d: got sq=%b required sq=%b", k, order[k], expOrder[k]);
            else passCnt++;
            if (expOrder[k]) begin
                expW0 = 32'h5A00_0000 + 32'(sqK);
                sqK++;
            end else begin
                expW0 = 32'hA500_0000 + 32'(rqK);
                rqK++;
            end
            totalCnt++;
            if (w0Log[k] !== expW0)
                $display("FAIL rr_word0_%0d: got %h required %h", k, w0Log[k], expW0);
            else passCnt++;
        end
    endtask

    task automatic test_wait_request();
        logic [49:0] expTab [10];
        logic        waitAfter [10];
        int          pops = 0;
        expTab = '{{W0, T_BUSY}, {W1, T_BUSY}, {W1, T_BUSY}, {W1, T_BUSY}, {W1, T_BUSY},
                   {W2, T_BUSY}, {W3, T_BUSY}, {DI, T_POP}, {DI, T_IDLE}, {DI, T_IDLE}};
        waitAfter = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        wait_idle();
        push_sq(HEAD);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (SqDmaFifoPop) pops++;
            totalCnt++;
            if (dutView() !== expTab[c])
                $display("FAIL wait_cycle T+%0d: got %h required %h", c + 1, dutView(), expTab[c]);
            else passCnt++;
            DCSWaitRequest = waitAfter[c];
            // Corrupt the FIFO head after the grant; the latched request must be unaffected.
            if (c == 0) sqMem[sqRd] = 112'h0;
        end
        totalCnt++;
        if (pops != 1) $display("FAIL wait_pop_count: got %0d required 1", pops);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        logic [49:0] expTab [10];
        int          pops = 0;
        expTab = '{{W0, T_BUSY}, {W1, T_BUSY}, {W2, T_BUSY}, {DI, T_ZERO}, {W0, T_BUSY},
                   {W1, T_BUSY}, {W2, T_BUSY}, {W3, T_BUSY}, {DI, T_POP}, {DI, T_IDLE}};
        wait_idle();
        push_sq(HEAD);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (SqDmaFifoPop) pops++;
            totalCnt++;
            if (dutView() !== expTab[c])
                $display("FAIL reset_mid cycle %0d: got %h required %h", c + 1, dutView(), expTab[c]);
            else passCnt++;
            reset = (c == 2);
        end
        totalCnt++;
        if (pops != 1) $display("FAIL reset_mid_pop_count: got %0d required 1", pops);
        else passCnt++;
    endtask

    task automatic test_enable_drop();
        logic [49:0] expTab [15];
        expTab = '{{W0, T_BUSY}, {W1, T_BUSY}, {W2, T_BUSY}, {W3, T_BUSY}, {DI, T_POP},
                   {DI, T_IDLE}, {DI, T_IDLE}, {DI, T_IDLE}, {DI, T_IDLE},
                   {W0, T_BUSY}, {W1, T_BUSY}, {W2, T_BUSY}, {W3, T_BUSY}, {DI, T_POP},
                   {DI, T_IDLE}};
        wait_idle();
        push_sq(HEAD);
        push_sq(HEAD);
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            totalCnt++;
            if (dutView() !== expTab[c])
                $display("FAIL enable_cycle %0d: got %h required %h", c + 1, dutView(), expTab[c]);
            else passCnt++;
            if (c == 1) enable = 1'b0;
            if (c == 8) enable = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_sq_only();
        test_round_robin();
        test_wait_request();
        test_reset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCnt, totalCnt);
        $fatal(1, "timeout");
    end

endmodule
